// File: rtl/wishbone_multi_arbiter_pkg.sv
// Shared constants and types for the N-master Wishbone arbiter.
package wishbone_multi_arbiter_pkg;

  localparam int WB_ARB_MODE_FIXED = 0;
  localparam int WB_ARB_MODE_RR    = 1;

  localparam int WB_ARB_DATA_W = 16;
  localparam int WB_ARB_ADDR_W = 24;
  localparam int WB_ARB_SEL_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } wb_arb_state_e;

  function automatic int wb_arb_wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/wishbone_multi_arbiter_if.sv
// Per-master request bundle and the single shared bus port of the arbiter.
interface wb_arb_masters_if
  import wishbone_multi_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = WB_ARB_DATA_W,
  parameter int ADDR_W    = WB_ARB_ADDR_W,
  parameter int SEL_W     = WB_ARB_SEL_W
);
  logic [N_MASTERS-1:0]        i_m_cyc;
  logic [N_MASTERS-1:0]        i_m_stb;
  logic [N_MASTERS-1:0]        i_m_we;
  logic [N_MASTERS*ADDR_W-1:0] i_m_adr;
  logic [N_MASTERS*DATA_W-1:0] i_m_dat;
  logic [N_MASTERS*SEL_W-1:0]  i_m_sel;
  logic [N_MASTERS-1:0]        i_m_burst4;
  logic [N_MASTERS-1:0]        i_m_burst8;
  logic [N_MASTERS-1:0]        o_m_ack;
  logic [N_MASTERS-1:0]        o_m_err;
  logic [N_MASTERS-1:0]        o_m_rty;

  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel, i_m_burst4, i_m_burst8,
    input  o_m_ack, o_m_err, o_m_rty
  );

  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel, i_m_burst4, i_m_burst8,
    output o_m_ack, o_m_err, o_m_rty
  );
endinterface

interface wb_arb_bus_if
  import wishbone_multi_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_ARB_DATA_W,
  parameter int ADDR_W = WB_ARB_ADDR_W,
  parameter int SEL_W  = WB_ARB_SEL_W
);
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_o_dat;
  logic [SEL_W-1:0]  wb_sel;
  logic              wb_4_burst;
  logic              wb_8_burst;
  logic              wb_ack;
  logic              wb_err;
  logic              wb_rty;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst,
    input  wb_ack, wb_err, wb_rty
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst,
    output wb_ack, wb_err, wb_rty
  );
endinterface

// File: rtl/wishbone_multi_arbiter_pick.sv
// Rotating priority encoder: first set request at or after i_start, wrapping.
module wb_arb_pick
  import wishbone_multi_arbiter_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int               w_pos;
  logic [IDX_W-1:0] w_j;

  // Scan N positions starting at i_start and keep the first hit
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_pos    = 0;
    w_j      = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_start) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end else begin
        w_pos = w_pos;
      end
      w_j = IDX_W'(w_pos);
      if (!o_valid && i_req[w_j]) begin
        o_valid       = 1'b1;
        o_idx         = w_j;
        o_onehot[w_j] = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/wishbone_multi_arbiter.sv
// N-master Wishbone arbiter: picks an owner, holds it until its cyc drops,
// muxes its request onto the shared bus and routes responses back to it.
module wishbone_multi_arbiter
  import wishbone_multi_arbiter_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  parameter  int DATA_W    = WB_ARB_DATA_W,
  parameter  int ADDR_W    = WB_ARB_ADDR_W,
  parameter  int SEL_W     = WB_ARB_SEL_W,
  parameter  int MODE      = WB_ARB_MODE_FIXED,
  localparam int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wb_arb_masters_if.slave      m_if,
  wb_arb_bus_if.master         bus_if,
  output logic [N_MASTERS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_busy
);

  wb_arb_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_owner, w_owner_nxt;
  logic [IDX_W-1:0]     r_last,  w_last_nxt;
  logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]     w_start;
  logic [N_MASTERS-1:0] w_pick_onehot;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic [31:0]          w_owner_ext;
  logic                 w_own_cyc;

  // Round robin resumes one past the last grant; fixed priority always scans from 0
  assign w_start = (MODE == WB_ARB_MODE_RR) ? IDX_W'(wb_arb_wrap_inc(int'(r_last), N_MASTERS))
                                            : '0;

  wb_arb_pick #(.N(N_MASTERS)) u_pick (
    .i_req    (m_if.i_m_cyc),
    .i_start  (w_start),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // State, owner, last-owner and grant registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(N_MASTERS - 1);
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Next owner: hold while the owner keeps cyc, otherwise re-pick in the same edge
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_pick_idx;
          w_last_nxt  = w_pick_idx;
          w_grant_nxt = w_pick_onehot;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (m_if.i_m_cyc[r_owner]) begin
          w_state_nxt = ST_OWNED;
        end else if (w_pick_valid) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_pick_idx;
          w_last_nxt  = w_pick_idx;
          w_grant_nxt = w_pick_onehot;
        end else begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = '0;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = '0;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign w_owner_ext = 32'(r_owner);

  // Request mux onto the bus and response routing back to the owner only
  always_comb begin
    w_own_cyc         = 1'b0;
    bus_if.wb_cyc     = 1'b0;
    bus_if.wb_stb     = 1'b0;
    bus_if.wb_we      = 1'b0;
    bus_if.wb_adr     = '0;
    bus_if.wb_o_dat   = '0;
    bus_if.wb_sel     = '0;
    bus_if.wb_4_burst = 1'b0;
    bus_if.wb_8_burst = 1'b0;
    m_if.o_m_ack      = '0;
    m_if.o_m_err      = '0;
    m_if.o_m_rty      = '0;
    if (r_state == ST_OWNED) begin
      w_own_cyc         = m_if.i_m_cyc[r_owner];
      bus_if.wb_cyc     = w_own_cyc;
      bus_if.wb_stb     = m_if.i_m_stb[r_owner];
      bus_if.wb_we      = m_if.i_m_we[r_owner];
      bus_if.wb_adr     = m_if.i_m_adr[w_owner_ext*ADDR_W +: ADDR_W];
      bus_if.wb_o_dat   = m_if.i_m_dat[w_owner_ext*DATA_W +: DATA_W];
      bus_if.wb_sel     = m_if.i_m_sel[w_owner_ext*SEL_W +: SEL_W];
      bus_if.wb_4_burst = m_if.i_m_burst4[r_owner];
      bus_if.wb_8_burst = m_if.i_m_burst8[r_owner];
      m_if.o_m_ack[r_owner] = bus_if.wb_ack & w_own_cyc;
      m_if.o_m_err[r_owner] = bus_if.wb_err & w_own_cyc;
      m_if.o_m_rty[r_owner] = bus_if.wb_rty & w_own_cyc;
    end else begin
      w_own_cyc = 1'b0;
    end
  end

  assign o_grant     = r_grant;
  assign o_grant_idx = r_owner;
  assign o_busy      = (r_state == ST_OWNED);

endmodule

// File: tb/tb_wishbone_multi_arbiter.sv
// Bench for three arbiter instances (fixed N=2, round robin N=4, fixed N=4)
// sharing one stimulus stream, checked against an integer-owner reference model.
module tb_wishbone_multi_arbiter;
  import wishbone_multi_arbiter_pkg::*;

  localparam int ND = 3;

  logic        clk   = 1'b0;
  logic        rst_v = 1'b1;
  logic [3:0]  cyc_v = 4'h0, stb_v = 4'h0, we_v = 4'h0, b4_v = 4'h0, b8_v = 4'h0;
  logic [23:0] adr_v [4];
  logic [15:0] dat_v [4];
  logic [1:0]  sel_v [4];
  logic        ack_v = 1'b0, err_v = 1'b0, rty_v = 1'b0;

  int checks = 0;
  int errors = 0;
  int md_owner [ND];
  int md_last  [ND];
  int rr_exp   [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  wb_arb_masters_if #(.N_MASTERS(2)) mif0 ();
  wb_arb_masters_if #(.N_MASTERS(4)) mif1 ();
  wb_arb_masters_if #(.N_MASTERS(4)) mif2 ();
  wb_arb_bus_if bif0 ();
  wb_arb_bus_if bif1 ();
  wb_arb_bus_if bif2 ();

  assign mif0.i_m_cyc    = cyc_v[1:0];
  assign mif0.i_m_stb    = stb_v[1:0];
  assign mif0.i_m_we     = we_v[1:0];
  assign mif0.i_m_burst4 = b4_v[1:0];
  assign mif0.i_m_burst8 = b8_v[1:0];
  assign mif0.i_m_adr    = {adr_v[1], adr_v[0]};
  assign mif0.i_m_dat    = {dat_v[1], dat_v[0]};
  assign mif0.i_m_sel    = {sel_v[1], sel_v[0]};
  assign mif1.i_m_cyc    = cyc_v;
  assign mif1.i_m_stb    = stb_v;
  assign mif1.i_m_we     = we_v;
  assign mif1.i_m_burst4 = b4_v;
  assign mif1.i_m_burst8 = b8_v;
  assign mif1.i_m_adr    = {adr_v[3], adr_v[2], adr_v[1], adr_v[0]};
  assign mif1.i_m_dat    = {dat_v[3], dat_v[2], dat_v[1], dat_v[0]};
  assign mif1.i_m_sel    = {sel_v[3], sel_v[2], sel_v[1], sel_v[0]};
  assign mif2.i_m_cyc    = cyc_v;
  assign mif2.i_m_stb    = stb_v;
  assign mif2.i_m_we     = we_v;
  assign mif2.i_m_burst4 = b4_v;
  assign mif2.i_m_burst8 = b8_v;
  assign mif2.i_m_adr    = {adr_v[3], adr_v[2], adr_v[1], adr_v[0]};
  assign mif2.i_m_dat    = {dat_v[3], dat_v[2], dat_v[1], dat_v[0]};
  assign mif2.i_m_sel    = {sel_v[3], sel_v[2], sel_v[1], sel_v[0]};
  assign bif0.wb_ack = ack_v;  assign bif0.wb_err = err_v;  assign bif0.wb_rty = rty_v;
  assign bif1.wb_ack = ack_v;  assign bif1.wb_err = err_v;  assign bif1.wb_rty = rty_v;
  assign bif2.wb_ack = ack_v;  assign bif2.wb_err = err_v;  assign bif2.wb_rty = rty_v;

  logic [1:0] g0;
  logic [3:0] g1, g2;
  logic       ix0;
  logic [1:0] ix1, ix2;
  logic       bz0, bz1, bz2;

  wishbone_multi_arbiter #(.N_MASTERS(2), .MODE(WB_ARB_MODE_FIXED)) dut0 (
    .i_clk(clk), .i_rst(rst_v), .m_if(mif0), .bus_if(bif0),
    .o_grant(g0), .o_grant_idx(ix0), .o_busy(bz0));
  wishbone_multi_arbiter #(.N_MASTERS(4), .MODE(WB_ARB_MODE_RR)) dut1 (
    .i_clk(clk), .i_rst(rst_v), .m_if(mif1), .bus_if(bif1),
    .o_grant(g1), .o_grant_idx(ix1), .o_busy(bz1));
  wishbone_multi_arbiter #(.N_MASTERS(4), .MODE(WB_ARB_MODE_FIXED)) dut2 (
    .i_clk(clk), .i_rst(rst_v), .m_if(mif2), .bus_if(bif2),
    .o_grant(g2), .o_grant_idx(ix2), .o_busy(bz2));

  // Observed outputs, widened to four masters so one checker covers every instance
  logic [3:0]  ob_grant [ND], ob_ack [ND], ob_err [ND], ob_rty [ND];
  logic [1:0]  ob_idx [ND], ob_sel [ND];
  logic        ob_busy [ND], ob_cyc [ND], ob_stb [ND], ob_we [ND], ob_b4 [ND], ob_b8 [ND];
  logic [23:0] ob_adr [ND];
  logic [15:0] ob_dat [ND];

  assign ob_grant[0] = {2'b00, g0};  assign ob_grant[1] = g1;  assign ob_grant[2] = g2;
  assign ob_idx[0]   = {1'b0, ix0};  assign ob_idx[1]   = ix1; assign ob_idx[2]   = ix2;
  assign ob_busy[0]  = bz0;          assign ob_busy[1]  = bz1; assign ob_busy[2]  = bz2;
  assign ob_ack[0] = {2'b00, mif0.o_m_ack};  assign ob_ack[1] = mif1.o_m_ack;  assign ob_ack[2] = mif2.o_m_ack;
  assign ob_err[0] = {2'b00, mif0.o_m_err};  assign ob_err[1] = mif1.o_m_err;  assign ob_err[2] = mif2.o_m_err;
  assign ob_rty[0] = {2'b00, mif0.o_m_rty};  assign ob_rty[1] = mif1.o_m_rty;  assign ob_rty[2] = mif2.o_m_rty;
  assign ob_cyc[0] = bif0.wb_cyc;      assign ob_cyc[1] = bif1.wb_cyc;      assign ob_cyc[2] = bif2.wb_cyc;
  assign ob_stb[0] = bif0.wb_stb;      assign ob_stb[1] = bif1.wb_stb;      assign ob_stb[2] = bif2.wb_stb;
  assign ob_we[0]  = bif0.wb_we;       assign ob_we[1]  = bif1.wb_we;       assign ob_we[2]  = bif2.wb_we;
  assign ob_b4[0]  = bif0.wb_4_burst;  assign ob_b4[1]  = bif1.wb_4_burst;  assign ob_b4[2]  = bif2.wb_4_burst;
  assign ob_b8[0]  = bif0.wb_8_burst;  assign ob_b8[1]  = bif1.wb_8_burst;  assign ob_b8[2]  = bif2.wb_8_burst;
  assign ob_adr[0] = bif0.wb_adr;      assign ob_adr[1] = bif1.wb_adr;      assign ob_adr[2] = bif2.wb_adr;
  assign ob_dat[0] = bif0.wb_o_dat;    assign ob_dat[1] = bif1.wb_o_dat;    assign ob_dat[2] = bif2.wb_o_dat;
  assign ob_sel[0] = bif0.wb_sel;      assign ob_sel[1] = bif1.wb_sel;      assign ob_sel[2] = bif2.wb_sel;

  function automatic int dn(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // Requester search: round robin (instance 1) from last+1, fixed from 0
  function automatic int pick(input int d);
    int start;
    start = (d == 1) ? (md_last[d] + 1) % dn(d) : 0;
    for (int k = 0; k < dn(d); k++) begin
      int j;
      j = (start + k) % dn(d);
      if (cyc_v[2'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic model_tick();
    for (int d = 0; d < ND; d++) begin
      if (rst_v) begin
        md_owner[d] = -1;
        md_last[d]  = dn(d) - 1;
      end else if (md_owner[d] < 0 || !cyc_v[2'(md_owner[d])]) begin
        int p;
        p = pick(d);
        md_owner[d] = p;
        if (p >= 0) md_last[d] = p;
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_comb();
    for (int d = 0; d < ND; d++) begin
      int          o;
      logic [1:0]  oi;
      logic        own, e_cyc;
      logic [3:0]  e_rsp;
      o     = md_owner[d];
      oi    = 2'(o);
      own   = (o >= 0);
      e_cyc = own & cyc_v[oi];
      e_rsp = e_cyc ? (4'b0001 << oi) : 4'b0000;
      chk("wb_cyc", d, 32'(ob_cyc[d]), 32'(e_cyc));
      chk("wb_stb", d, 32'(ob_stb[d]), 32'(own & stb_v[oi]));
      chk("wb_we",  d, 32'(ob_we[d]),  32'(own & we_v[oi]));
      chk("wb_4_burst", d, 32'(ob_b4[d]), 32'(own & b4_v[oi]));
      chk("wb_8_burst", d, 32'(ob_b8[d]), 32'(own & b8_v[oi]));
      chk("wb_adr", d, 32'(ob_adr[d]), 32'(own ? adr_v[oi] : 24'h0));
      chk("wb_dat", d, 32'(ob_dat[d]), 32'(own ? dat_v[oi] : 16'h0));
      chk("wb_sel", d, 32'(ob_sel[d]), 32'(own ? sel_v[oi] : 2'b00));
      chk("m_ack", d, 32'(ob_ack[d]), 32'(ack_v ? e_rsp : 4'b0000));
      chk("m_err", d, 32'(ob_err[d]), 32'(err_v ? e_rsp : 4'b0000));
      chk("m_rty", d, 32'(ob_rty[d]), 32'(rty_v ? e_rsp : 4'b0000));
    end
  endtask

  task automatic chk_regs();
    for (int d = 0; d < ND; d++) begin
      logic own;
      own = (md_owner[d] >= 0);
      chk("grant", d, 32'(ob_grant[d]), own ? 32'(4'b0001 << 2'(md_owner[d])) : 32'h0);
      chk("busy",  d, 32'(ob_busy[d]), 32'(own));
      if (own) chk("grant_idx", d, 32'(ob_idx[d]), 32'(md_owner[d]));
    end
  endtask

  task automatic rand_side();
    stb_v = 4'($urandom);
    we_v  = 4'($urandom);
    b4_v  = 4'($urandom);
    b8_v  = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      adr_v[i] = 24'($urandom);
      dat_v[i] = 16'($urandom);
      sel_v[i] = 2'($urandom);
    end
  endtask

  task automatic apply();
    #1;
    chk_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
    chk_regs();
  endtask

  task automatic step();
    apply();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rand_side();
    // Reset state
    rst_v = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) chk("rst_idx", d, 32'(ob_idx[d]), 32'h0);
    apply();
    tick();
    rst_v = 1'b0;

    // Fixed priority, simultaneous request: master 0 first, then master 1
    cyc_v = 4'b0011; rand_side();
    step();
    chk("fx_first", 0, 32'(ob_grant[0]), 32'h1);
    step(); step();
    cyc_v = 4'b0010; rand_side();
    step();
    chk("fx_handover", 0, 32'(ob_grant[0]), 32'h2);
    step();

    // Round robin with every master requesting, each owner releasing after two acks
    rst_v = 1'b1; step(); rst_v = 1'b0;
    cyc_v = 4'hF; rand_side();
    step();
    for (int g = 0; g < 5; g++) begin
      chk("rr_order", 1, 32'(ob_idx[1]), 32'(rr_exp[g]));
      ack_v = 1'b1; rand_side(); step();
      rand_side(); step();
      ack_v = 1'b0;
      cyc_v = 4'hF & ~(4'b0001 << 2'(md_owner[1]));
      step();
      cyc_v = 4'hF;
    end

    // Master 2 owns an 8-beat burst while master 0 keeps requesting
    cyc_v = 4'b0000; step();
    cyc_v = 4'b0100; rand_side(); b8_v[2] = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      cyc_v = 4'b0101; rand_side(); b8_v[2] = 1'b1; ack_v = 1'b1;
      apply();
      chk("burst8_hint", 2, 32'(ob_b8[2]), 32'h1);
      tick();
      chk("no_preempt", 2, 32'(ob_grant[2]), 32'h4);
    end
    ack_v = 1'b0; cyc_v = 4'b0001;
    step();

    // Response routing to master 1, then a stray ack while idle
    cyc_v = 4'b0000; step();
    cyc_v = 4'b0010; rand_side(); step();
    ack_v = 1'b1; err_v = 1'b1;
    apply();
    chk("route_ack", 0, 32'(ob_ack[0]), 32'h2);
    chk("route_err", 0, 32'(ob_err[0]), 32'h2);
    chk("route_ack", 1, 32'(ob_ack[1]), 32'h2);
    tick();
    ack_v = 1'b0; err_v = 1'b0; cyc_v = 4'b0000;
    step();
    ack_v = 1'b1;
    apply();
    for (int d = 0; d < ND; d++) chk("stray_ack", d, 32'(ob_ack[d]), 32'h0);
    tick();
    ack_v = 1'b0;

    // Reset in the middle of a burst, then round robin restarts at master 0
    cyc_v = 4'b0100; ack_v = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_side(); b8_v[2] = 1'b1; step(); end
    rst_v = 1'b1;
    apply();
    tick();
    chk("rst_grant", 2, 32'(ob_grant[2]), 32'h0);
    chk("rst_busy",  2, 32'(ob_busy[2]), 32'h0);
    rst_v = 1'b0; ack_v = 1'b0; cyc_v = 4'hF;
    apply();
    chk("rst_cyc", 2, 32'(ob_cyc[2]), 32'h0);
    tick();
    chk("rr_after_rst", 1, 32'(ob_idx[1]), 32'h0);
    chk("rr_after_rst_busy", 1, 32'(ob_busy[1]), 32'h1);

    // Random traffic with sticky requests, random responses and rare resets
    for (int n = 0; n < 600; n++) begin
      cyc_v = cyc_v ^ (4'($urandom) & 4'($urandom));
      rand_side();
      ack_v = ($urandom_range(0, 3) == 0);
      err_v = ($urandom_range(0, 7) == 0);
      rty_v = ($urandom_range(0, 7) == 0);
      rst_v = ($urandom_range(0, 63) == 0);
      step();
    end
    rst_v = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
